// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter
// Round-robin arbiter that shares one UART TX byte stream between N_SRC
// framed byte sources. The granted source owns the transmitter until its
// tlast byte is accepted, so messages never interleave. A stall timeout
// takes the transmitter back from a source that goes quiet mid-message.
// The outgoing byte is held in an output register.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   s_tdata      source bytes, source i at [i*N_BITS +: N_BITS]
//   s_tvalid     per-source byte valid
//   s_tlast      per-source last byte of message
//   s_tready     per-source accept (only the owner can see it high)
//   uart_tdata   registered byte to the UART TX core
//   uart_tvalid  registered byte valid
//   uart_tready  UART TX core ready
//   grant        one-hot transmitter owner, zero when idle
//   busy         high while a source owns the transmitter
//   abort        one-cycle pulse when a message is cut by the timeout
module uart_msg_arbiter #(
   parameter int N_SRC   = 4,
   parameter int N_BITS  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_SRC*N_BITS-1:0] s_tdata,
   input  logic [N_SRC-1:0]        s_tvalid,
   input  logic [N_SRC-1:0]        s_tlast,
   output logic [N_SRC-1:0]        s_tready,
   output logic [N_BITS-1:0]       uart_tdata,
   output logic                    uart_tvalid,
   input  logic                    uart_tready,
   output logic [N_SRC-1:0]        grant,
   output logic                    busy,
   output logic                    abort
);

   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [PW:0]   NSRC_W     = (PW + 1)'(N_SRC);
   // Abort is raised on the edge where the counter would reach TIMEOUT.
   localparam logic [CW-1:0] STALL_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam bit            TO_EN      = (TIMEOUT > 0);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t              r_state;
   logic [N_SRC-1:0]    r_grant;
   logic [PW-1:0]       r_ptr;
   logic [CW-1:0]       r_cnt;
   logic [N_BITS-1:0]   r_tdata;
   logic                r_tvalid;
   logic                r_busy;
   logic                r_abort;

   logic [2*N_SRC-1:0]  w_req_dbl;
   logic [N_SRC-1:0]    w_rot;
   logic [PW-1:0]       w_off;
   logic                w_any;
   logic [PW:0]         w_sum;
   logic [PW:0]         w_sel;
   logic [N_SRC-1:0]    w_sel_oh;
   logic [PW-1:0]       w_gidx;
   logic [PW:0]         w_ginc;
   logic [PW-1:0]       w_next_ptr;
   logic [N_BITS-1:0]   w_gdata;
   logic                w_gvalid;
   logic                w_glast;
   logic                w_out_free;
   logic                w_accept;
   logic                w_stall;
   logic                w_timeout;

   // Rotate requests so that bit 0 is the source at the priority pointer.
   assign w_req_dbl = {s_tvalid, s_tvalid} >> r_ptr;
   assign w_rot     = w_req_dbl[N_SRC-1:0];

   // First set bit of the rotated request vector, then undo the rotation.
   always_comb begin
      w_off = '0;
      w_any = 1'b0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         w_off = w_rot[k] ? PW'(k) : w_off;
         w_any = w_any | w_rot[k];
      end
      w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
      w_sel    = (w_sum >= NSRC_W) ? (w_sum - NSRC_W) : w_sum;
      w_sel_oh = N_SRC'(1) << w_sel[PW-1:0];
   end

   // Owner index and owner byte from the one-hot grant.
   always_comb begin
      w_gidx  = '0;
      w_gdata = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_gidx  = r_grant[i] ? PW'(i) : w_gidx;
         w_gdata = r_grant[i] ? s_tdata[i*N_BITS +: N_BITS] : w_gdata;
      end
      w_ginc     = {1'b0, w_gidx} + (PW + 1)'(1);
      w_next_ptr = (w_ginc == NSRC_W) ? '0 : w_ginc[PW-1:0];
   end

   // Handshake qualifiers; grant is all-zero outside XFER so s_tready is too.
   assign w_gvalid   = |(s_tvalid & r_grant);
   assign w_glast    = |(s_tlast & r_grant);
   assign w_out_free = ~r_tvalid | uart_tready;
   assign w_accept   = (r_state == ST_XFER) & w_gvalid & w_out_free;
   // Back-pressure from the UART side is not a stall: only a missing source byte counts.
   assign w_stall    = (r_state == ST_XFER) & ~w_gvalid;
   assign w_timeout  = TO_EN & w_stall & (r_cnt == STALL_LAST);

   assign s_tready    = r_grant & {N_SRC{w_out_free}};
   assign grant       = r_grant;
   assign busy        = r_busy;
   assign abort       = r_abort;
   assign uart_tdata  = r_tdata;
   assign uart_tvalid = r_tvalid;

   // Arbitration FSM, stall counter and output byte register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_abort <= 1'b0;

         // The output register keeps draining after release, so it is
         // independent of the arbitration state.
         if (w_accept) begin
            r_tdata  <= w_gdata;
            r_tvalid <= 1'b1;
         end else if (uart_tready) begin
            r_tvalid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_sel_oh;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_accept && w_glast) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_IDLE;
               end else if (w_timeout) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_abort <= 1'b1;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_IDLE;
               end else if (w_accept) begin
                  r_cnt <= '0;
               end else if (w_stall && TO_EN) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
